// File: rtl/fg_pkg.sv
// Shared FSM encoding and default timing constants for the function-generator DAC interface.
package fg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    SETTLE
  } fg_state_t;

  localparam int unsigned DEF_SETUP_CYCLES    = 1;
  localparam int unsigned DEF_WR_PULSE_CYCLES = 2;
  localparam int unsigned DEF_SETTLE_CYCLES   = 500;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fg_dac_if_if.sv
// Sample-in / DAC-out signal bundle; dropCount_o exists only with FG_DAC_DROP_COUNT_EN.
interface fg_dac_if_if #(
  parameter int unsigned BITWIDTH = 8
);
  logic                enable_i;
  logic [BITWIDTH-1:0] sample_i;
  logic                sampleValid_i;
  logic [BITWIDTH-1:0] dac_data_o;
  logic                dac_wr_n_o;
  logic                dac_clr_n_o;
  logic                dac_pd_n_o;
  logic                busy_o;
`ifdef FG_DAC_DROP_COUNT_EN
  logic [7:0]          dropCount_o;
`endif

  modport master (
    output enable_i, sample_i, sampleValid_i,
`ifdef FG_DAC_DROP_COUNT_EN
    input  dropCount_o,
`endif
    input  dac_data_o, dac_wr_n_o, dac_clr_n_o, dac_pd_n_o, busy_o
  );

  modport slave (
    input  enable_i, sample_i, sampleValid_i,
`ifdef FG_DAC_DROP_COUNT_EN
    output dropCount_o,
`endif
    output dac_data_o, dac_wr_n_o, dac_clr_n_o, dac_pd_n_o, busy_o
  );
endinterface

// File: rtl/fg_phase_counter.sv
// Loadable down-counter shared by the SETUP, STROBE and SETTLE phases; done_o when at zero.
module fg_phase_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!rstn_i)          cnt <= '0;
    else if (load_i)      cnt <= load_val_i;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done_o = (cnt == '0);
endmodule

// File: rtl/fg_dac_if.sv
// Parallel DAC write sequencer with a one-entry latest-wins pending sample.
// Optional drop counter output enabled by defining FG_DAC_DROP_COUNT_EN.
module fg_dac_if
  import fg_pkg::*;
#(
  parameter int unsigned BITWIDTH        = 8,
  parameter int unsigned SETUP_CYCLES    = DEF_SETUP_CYCLES,
  parameter int unsigned WR_PULSE_CYCLES = DEF_WR_PULSE_CYCLES,
  parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES
) (
  input logic        clk_i,
  input logic        rstn_i,
  fg_dac_if_if.slave bus
);
  localparam int unsigned CW = $clog2(max3(SETUP_CYCLES, WR_PULSE_CYCLES, SETTLE_CYCLES)) + 1;

  fg_state_t           state, state_nxt;
  logic                cnt_load, cnt_done;
  logic [CW-1:0]       cnt_val;
  logic                accept, settle_exit, start_new, start_pend, store_pend, wr_n_nxt;
  logic                pend_valid;
  logic [BITWIDTH-1:0] pend_data, data_r;
  logic                wr_n_r, clr_n_r, pd_n_r;

  fg_phase_counter #(.WIDTH(CW)) u_phase_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (cnt_done) state_nxt = STROBE;
      STROBE:  if (cnt_done) state_nxt = HOLD;
      HOLD:    state_nxt = SETTLE;
      SETTLE:  if (cnt_done) state_nxt = (accept || (pend_valid && bus.enable_i)) ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SETUP loads the full count, so it spans SETUP_CYCLES+1 cycles including the load cycle.
  always_comb begin
    accept      = bus.sampleValid_i && bus.enable_i;
    settle_exit = (state == SETTLE) && cnt_done;
    start_new   = accept && ((state == IDLE) || settle_exit);
    start_pend  = settle_exit && !accept && pend_valid && bus.enable_i;
    store_pend  = accept && !start_new;
    wr_n_nxt    = (state_nxt != STROBE);
    cnt_load    = (state_nxt != state);
    cnt_val     = '0;
    case (state_nxt)
      SETUP:   cnt_val = CW'(SETUP_CYCLES);
      STROBE:  cnt_val = CW'(WR_PULSE_CYCLES - 1);
      SETTLE:  cnt_val = CW'(SETTLE_CYCLES - 1);
      default: cnt_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      data_r     <= '0;
      wr_n_r     <= 1'b1;
      clr_n_r    <= 1'b0;
      pd_n_r     <= 1'b1;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      clr_n_r <= 1'b1;
      pd_n_r  <= 1'b1;
      wr_n_r  <= wr_n_nxt;
      if (start_new)       data_r <= bus.sample_i;
      else if (start_pend) data_r <= pend_data;
      if (!bus.enable_i) begin
        pend_valid <= 1'b0;
      end else if (store_pend) begin
        pend_valid <= 1'b1;
        pend_data  <= bus.sample_i;
      end else if (settle_exit) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign bus.dac_data_o  = data_r;
  assign bus.dac_wr_n_o  = wr_n_r;
  assign bus.dac_clr_n_o = clr_n_r;
  assign bus.dac_pd_n_o  = pd_n_r;
  assign bus.busy_o      = (state != IDLE) || pend_valid;

`ifdef FG_DAC_DROP_COUNT_EN
  // Any accepted strobe while a sample is pending discards that pending sample.
  logic       drop;
  logic [7:0] drop_cnt;

  assign drop = accept && pend_valid;

  always_ff @(posedge clk_i) begin
    if (!rstn_i)                      drop_cnt <= '0;
    else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 8'd1;
  end

  assign bus.dropCount_o = drop_cnt;
`endif
endmodule

// File: tb/tb_fg_dac_if.sv
// Scoreboard bench for fg_dac_if: a default-timing instance and a minimum-timing instance.
module tb_fg_dac_if;
  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  logic       prev_wr  [2];
  logic [7:0] prev_data[2];
  logic [7:0] fall_data[2];
  int         low_len  [2];
  int         high_len [2];
  logic       abort    [2];

  fg_dac_if_if #(.BITWIDTH(8)) bus_m ();
  fg_dac_if_if #(.BITWIDTH(8)) bus_f ();

  fg_dac_if #(.BITWIDTH(8)) u_dut_m (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus_m)
  );

  fg_dac_if #(.BITWIDTH(8), .SETUP_CYCLES(1), .WR_PULSE_CYCLES(1), .SETTLE_CYCLES(1)) u_dut_f (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_wr[i] = 1'b1; prev_data[i] = '0; fall_data[i] = '0;
      low_len[i] = 0; high_len[i] = 99; abort[i] = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle write-strobe monitor: pops the scoreboard on every falling edge of wr_n.
  task automatic mon_step(input int id, input logic wr_n, input logic [7:0] data,
                          input logic rst_ok, input int pw);
    logic [7:0] exp;
    if (wr_n === 1'b0) begin
      if (prev_wr[id]) begin
        checks++;
        if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
          errors++;
          $display("FAIL write_unexpected dut%0d: data=%h, no write expected", id, data);
        end else begin
          exp = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if (data !== exp) begin
            errors++;
            $display("FAIL write_data dut%0d: got %h expected %h", id, data, exp);
          end
        end
        checks++;
        if (prev_data[id] !== data) begin
          errors++;
          $display("FAIL setup_stable dut%0d: got %h expected %h", id, prev_data[id], data);
        end
        checks++;
        if (high_len[id] < 2) begin
          errors++;
          $display("FAIL write_gap dut%0d: got %0d high cycles expected >=2", id, high_len[id]);
        end
        low_len[id]   = 1;
        fall_data[id] = data;
        abort[id]     = 1'b0;
      end else begin
        low_len[id]++;
        checks++;
        if (data !== fall_data[id]) begin
          errors++;
          $display("FAIL strobe_stable dut%0d: got %h expected %h", id, data, fall_data[id]);
        end
      end
      if (rst_ok !== 1'b1) abort[id] = 1'b1;
    end else begin
      if (!prev_wr[id]) begin
        if (!abort[id]) begin
          checks++;
          if (low_len[id] != pw) begin
            errors++;
            $display("FAIL pulse_width dut%0d: got %0d expected %0d", id, low_len[id], pw);
          end
          checks++;
          if (data !== fall_data[id]) begin
            errors++;
            $display("FAIL hold_stable dut%0d: got %h expected %h", id, data, fall_data[id]);
          end
        end
        high_len[id] = 1;
      end else begin
        high_len[id]++;
      end
    end
    prev_wr[id]   = (wr_n === 1'b0) ? 1'b0 : 1'b1;
    prev_data[id] = data;
  endtask

  always @(negedge clk) mon_step(0, bus_m.dac_wr_n_o, bus_m.dac_data_o, rstn, 2);
  always @(negedge clk) mon_step(1, bus_f.dac_wr_n_o, bus_f.dac_data_o, rstn, 1);

  task automatic strobe_m(input logic [7:0] v);
    bus_m.sample_i      = v;
    bus_m.sampleValid_i = 1'b1;
    tick();
    bus_m.sampleValid_i = 1'b0;
  endtask

  task automatic wait_idle(input int id, input int max_cycles);
    int n = 0;
    logic b;
    b = (id == 0) ? bus_m.busy_o : bus_f.busy_o;
    while (b !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
      b = (id == 0) ? bus_m.busy_o : bus_f.busy_o;
    end
    checks++;
    if (b !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout dut%0d: busy=%b after %0d cycles, expected 0", id, b, n);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus_m.dac_data_o !== 8'h00 || bus_m.dac_wr_n_o !== 1'b1 || bus_m.dac_clr_n_o !== 1'b0 ||
        bus_m.dac_pd_n_o !== 1'b1 || bus_m.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data=%h wr_n=%b clr_n=%b pd_n=%b busy=%b expected 00 1 0 1 0",
               bus_m.dac_data_o, bus_m.dac_wr_n_o, bus_m.dac_clr_n_o, bus_m.dac_pd_n_o, bus_m.busy_o);
    end
    checks++;
    if (bus_f.dac_wr_n_o !== 1'b1 || bus_f.busy_o !== 1'b0 || bus_f.dac_clr_n_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_fast: wr_n=%b busy=%b clr_n=%b expected 1 0 0",
               bus_f.dac_wr_n_o, bus_f.busy_o, bus_f.dac_clr_n_o);
    end
`ifdef FG_DAC_DROP_COUNT_EN
    checks++;
    if (bus_m.dropCount_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop_count: got %0d expected 0", bus_m.dropCount_o);
    end
`endif
    rstn = 1'b1;
    tick();
    checks++;
    if (bus_m.dac_clr_n_o !== 1'b1) begin
      errors++;
      $display("FAIL clr_release: got %b expected 1", bus_m.dac_clr_n_o);
    end
  endtask

  task automatic test_single_write();
    logic exp_wr, exp_busy;
    bus_m.enable_i = 1'b1;
    repeat (2) tick();
    exp_q0.push_back(8'hA5);
    strobe_m(8'hA5);
    checks++;
    if (bus_m.dac_data_o !== 8'hA5 || bus_m.dac_wr_n_o !== 1'b1 || bus_m.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL load_edge: data=%h wr_n=%b busy=%b expected a5 1 1",
               bus_m.dac_data_o, bus_m.dac_wr_n_o, bus_m.busy_o);
    end
    for (int j = 1; j <= 506; j++) begin
      tick();
      exp_wr   = (j == 2 || j == 3) ? 1'b0 : 1'b1;
      exp_busy = (j < 505) ? 1'b1 : 1'b0;
      checks++;
      if (bus_m.dac_wr_n_o !== exp_wr || bus_m.busy_o !== exp_busy || bus_m.dac_data_o !== 8'hA5) begin
        errors++;
        $display("FAIL single_timing edge+%0d: wr_n=%b busy=%b data=%h expected %b %b a5",
                 j, bus_m.dac_wr_n_o, bus_m.busy_o, bus_m.dac_data_o, exp_wr, exp_busy);
      end
    end
  endtask

  task automatic test_overwrite();
    exp_q0.push_back(8'h11);
    strobe_m(8'h11);
    repeat (39) tick();
    strobe_m(8'h22);
    repeat (9) tick();
    exp_q0.push_back(8'h33);
    strobe_m(8'h33);
    wait_idle(0, 1500);
    checks++;
    if (bus_m.dac_data_o !== 8'h33) begin
      errors++;
      $display("FAIL overwrite_final_data: got %h expected 33", bus_m.dac_data_o);
    end
`ifdef FG_DAC_DROP_COUNT_EN
    checks++;
    if (bus_m.dropCount_o !== 8'd1) begin
      errors++;
      $display("FAIL overwrite_drop_count: got %0d expected 1", bus_m.dropCount_o);
    end
`endif
  endtask

  task automatic test_disabled();
    bus_m.enable_i = 1'b0;
    strobe_m(8'h7F);
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bus_m.dac_wr_n_o !== 1'b1 || bus_m.busy_o !== 1'b0 || bus_m.dac_data_o !== 8'h33) begin
        errors++;
        $display("FAIL disabled_ignore: wr_n=%b busy=%b data=%h expected 1 0 33",
                 bus_m.dac_wr_n_o, bus_m.busy_o, bus_m.dac_data_o);
      end
      tick();
    end
    // Pending sample must be flushed by enable low while the running write completes.
    bus_m.enable_i = 1'b1;
    exp_q0.push_back(8'h5A);
    strobe_m(8'h5A);
    repeat (5) tick();
    strobe_m(8'h6B);
    bus_m.enable_i = 1'b0;
    repeat (3) tick();
    bus_m.enable_i = 1'b1;
    wait_idle(0, 1500);
    checks++;
    if (bus_m.dac_data_o !== 8'h5A) begin
      errors++;
      $display("FAIL disable_flush_pending: got %h expected 5a", bus_m.dac_data_o);
    end
  endtask

  task automatic test_back_to_back();
    bus_f.enable_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == 5 || i == 10 || i == 15 || i == 19) exp_q1.push_back(8'(8'h40 + i));
      bus_f.sample_i      = 8'(8'h40 + i);
      bus_f.sampleValid_i = 1'b1;
      tick();
    end
    bus_f.sampleValid_i = 1'b0;
    wait_idle(1, 50);
    repeat (2) tick();
    checks++;
    if (bus_f.dac_data_o !== 8'h53) begin
      errors++;
      $display("FAIL b2b_final_data: got %h expected 53", bus_f.dac_data_o);
    end
`ifdef FG_DAC_DROP_COUNT_EN
    checks++;
    if (bus_f.dropCount_o !== 8'd15) begin
      errors++;
      $display("FAIL b2b_drop_count: got %0d expected 15", bus_f.dropCount_o);
    end
`endif
  endtask

  task automatic test_reset_mid_strobe();
    exp_q0.push_back(8'h3C);
    strobe_m(8'h3C);
    repeat (2) tick();
    checks++;
    if (bus_m.dac_wr_n_o !== 1'b0) begin
      errors++;
      $display("FAIL first_strobe_cycle: wr_n=%b expected 0", bus_m.dac_wr_n_o);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if (bus_m.dac_wr_n_o !== 1'b1 || bus_m.dac_clr_n_o !== 1'b0 || bus_m.dac_data_o !== 8'h00 ||
        bus_m.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: wr_n=%b clr_n=%b data=%h busy=%b expected 1 0 00 0",
               bus_m.dac_wr_n_o, bus_m.dac_clr_n_o, bus_m.dac_data_o, bus_m.busy_o);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (bus_m.dac_clr_n_o !== 1'b1 || bus_m.dac_wr_n_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort_release: clr_n=%b wr_n=%b expected 1 1",
               bus_m.dac_clr_n_o, bus_m.dac_wr_n_o);
    end
    repeat (4) tick();
  endtask

  initial begin
    rstn = 1'b0;
    bus_m.enable_i = 1'b0; bus_m.sample_i = '0; bus_m.sampleValid_i = 1'b0;
    bus_f.enable_i = 1'b0; bus_f.sample_i = '0; bus_f.sampleValid_i = 1'b0;
    test_reset();
    test_single_write();
    test_overwrite();
    test_disabled();
    test_back_to_back();
    test_reset_mid_strobe();
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL writes_missing: got %0d/%0d outstanding expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
